// File: rtl/encod16x4_queue_pkg.sv
// Shared widths, FSM state type and index helpers for the 16-to-4 event encoder.
// Pure definitions: no timing, no flow control.
package encod_pkg;

  localparam int IDX_W   = 4;
  localparam int N_LINES = 16;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_HOLD = 1'b1
  } enc_state_t;

  function automatic logic [N_LINES-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_LINES'(1) << idx;
  endfunction

endpackage

// File: rtl/encod16x4_queue_prio_sel16.sv
// First-set-bit finder over 16 lines, searching upward from a start offset and wrapping 15->0.
// Purely combinational, zero latency, no flow control.
module prio_sel16
  import encod_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*N_LINES-1:0] dbl;
  logic [N_LINES-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
  always_comb begin
    dbl = {vec, vec} >> start;
    rot = dbl[N_LINES-1:0];
    off = '0;
    for (int i = N_LINES-1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    found = |vec;
    idx   = off + start;
  end

endmodule

// File: rtl/encod16x4_queue.sv
// Collects event lines into a pending set and emits each as a 4-bit index; req->pending 1 edge, ->out_valid 2 edges.
// out_idx holds while out_valid & ~out_ready; pending keeps accumulating under backpressure, duplicates coalesce.
module encod16x4_queue
  import encod_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [N_LINES-1:0] pending,
  output logic               busy,
  output logic               merged
);

  enc_state_t         state;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   sel_idx;
  logic               found;
  logic               load;
  logic [N_LINES-1:0] load_mask;

  assign start = RR ? IDX_W'(last_idx + 1'b1) : '0;

  prio_sel16 u_sel (
    .vec   (pending),
    .start (start),
    .found (found),
    .idx   (sel_idx)
  );

  assign out_valid = (state == ENC_HOLD);
  assign busy      = out_valid | (|pending);

  // Load when the output stage is empty or is being drained this edge.
  assign load      = found & (~out_valid | out_ready);
  assign load_mask = load ? idx2onehot(sel_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENC_IDLE;
      pending  <= '0;
      out_idx  <= '0;
      last_idx <= 4'hF;
      merged   <= 1'b0;
    end else if (flush) begin
      state   <= ENC_IDLE;
      pending <= '0;
      merged  <= 1'b0;
    end else begin
      // A bit leaving for the output stage this edge is not a duplicate; req re-queues it.
      pending <= (pending & ~load_mask) | req;
      merged  <= |(req & pending & ~load_mask);
      if (load) begin
        state    <= ENC_HOLD;
        out_idx  <= sel_idx;
        last_idx <= sel_idx;
      end else if (out_valid && out_ready) begin
        state <= ENC_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_encod16x4_queue.sv
// Directed table-driven bench for encod16x4_queue, fixed-priority and round-robin instances side by side.
module tb_encod16x4_queue;
  import encod_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_LINES-1:0] req = '0;
  logic               flush = 1'b0;
  logic               out_ready = 1'b0;

  logic               v0, v1, busy0, busy1, m0, m1;
  logic [IDX_W-1:0]   idx0, idx1;
  logic [N_LINES-1:0] pend0, pend1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  encod16x4_queue #(.RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .flush(flush), .out_ready(out_ready),
    .out_valid(v0), .out_idx(idx0), .pending(pend0), .busy(busy0), .merged(m0)
  );

  encod16x4_queue #(.RR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .flush(flush), .out_ready(out_ready),
    .out_valid(v1), .out_idx(idx1), .pending(pend1), .busy(busy1), .merged(m1)
  );

  typedef struct {
    logic [15:0] req;
    logic        flush;
    logic        rdy;
    logic        v;
    logic [3:0]  idx;
    logic [15:0] pend;
    logic        busy;
    logic        m;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] r, input logic f, input logic rd, input logic v,
                     input logic [3:0] i, input logic [15:0] p, input logic b, input logic m);
    vec_t e;
    e.req = r; e.flush = f; e.rdy = rd; e.v = v; e.idx = i; e.pend = p; e.busy = b; e.m = m;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    req = '0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, " valid"},   32'(v0),    32'd0);
    chk({tag, " idx"},     32'(idx0),  32'd0);
    chk({tag, " pending"}, 32'(pend0), 32'd0);
    chk({tag, " busy"},    32'(busy0), 32'd0);
    chk({tag, " merged"},  32'(m0),    32'd0);
  endtask

  initial begin
    // req, flush, rdy | valid, idx, pending, busy, merged (after the edge)
    add(16'h0020, 0, 1,  0,  0, 16'h0020, 1, 0);
    add(16'h0000, 0, 1,  1,  5, 16'h0000, 1, 0);
    add(16'h0000, 0, 1,  0,  5, 16'h0000, 0, 0);
    add(16'h8421, 0, 1,  0,  5, 16'h8421, 1, 0);
    add(16'h0000, 0, 1,  1,  0, 16'h8420, 1, 0);
    add(16'h0000, 0, 1,  1,  5, 16'h8400, 1, 0);
    add(16'h0000, 0, 1,  1, 10, 16'h8000, 1, 0);
    add(16'h0000, 0, 1,  1, 15, 16'h0000, 1, 0);
    add(16'h0000, 0, 1,  0, 15, 16'h0000, 0, 0);
    add(16'h0003, 0, 0,  0, 15, 16'h0003, 1, 0);
    add(16'h0000, 0, 0,  1,  0, 16'h0002, 1, 0);
    for (int k = 0; k < 4; k++) add(16'h0000, 0, 0, 1, 0, 16'h0002, 1, 0);
    add(16'h0000, 0, 1,  1,  1, 16'h0000, 1, 0);
    add(16'h0000, 0, 1,  0,  1, 16'h0000, 0, 0);
    add(16'h0001, 0, 0,  0,  1, 16'h0001, 1, 0);
    add(16'h0010, 0, 0,  1,  0, 16'h0010, 1, 0);
    add(16'h0010, 0, 0,  1,  0, 16'h0010, 1, 1);
    add(16'h0000, 0, 0,  1,  0, 16'h0010, 1, 0);
    add(16'h0000, 0, 1,  1,  4, 16'h0000, 1, 0);
    add(16'h0010, 0, 0,  1,  4, 16'h0010, 1, 0);
    add(16'h0000, 0, 1,  1,  4, 16'h0000, 1, 0);
    add(16'h0000, 0, 1,  0,  4, 16'h0000, 0, 0);
    add(16'h0001, 0, 0,  0,  4, 16'h0001, 1, 0);
    add(16'h00F0, 0, 0,  1,  0, 16'h00F0, 1, 0);
    add(16'h0001, 1, 0,  0,  0, 16'h0000, 0, 0);
    add(16'h0000, 0, 1,  0,  0, 16'h0000, 0, 0);

    do_reset();
    chk_reset0("reset");
    chk("reset rr busy", 32'(busy1), 32'd0);

    foreach (tbl[i]) begin
      req = tbl[i].req; flush = tbl[i].flush; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("row%0d valid", i),   32'(v0),    32'(tbl[i].v));
      chk($sformatf("row%0d idx", i),     32'(idx0),  32'(tbl[i].idx));
      chk($sformatf("row%0d pending", i), 32'(pend0), 32'(tbl[i].pend));
      chk($sformatf("row%0d busy", i),    32'(busy0), 32'(tbl[i].busy));
      chk($sformatf("row%0d merged", i),  32'(m0),    32'(tbl[i].m));
    end

    // All 16 pending, streaming; the RR instance resumes after its last index (0), kept across flush.
    req = 16'hFFFF; flush = 1'b0; out_ready = 1'b1;
    step();
    chk("burst pending", 32'(pend0), 32'hFFFF);
    req = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("burst%0d valid", i), 32'(v0), 32'd1);
      chk($sformatf("burst%0d idx", i), 32'(idx0), 32'(i));
      chk($sformatf("burst%0d rr idx", i), 32'(idx1), 32'((i + 1) % 16));
    end
    step();
    chk("burst end valid", 32'(v0), 32'd0);
    chk("burst end busy", 32'(busy0), 32'd0);
    chk("burst end rr valid", 32'(v1), 32'd0);

    // Held all-ones request: RR walks 0..15 and wraps, fixed priority keeps picking 0.
    do_reset();
    req = 16'hFFFF; out_ready = 1'b1;
    step();
    for (int i = 0; i < 18; i++) begin
      step();
      chk($sformatf("rr%0d valid", i), 32'(v1), 32'd1);
      chk($sformatf("rr%0d idx", i), 32'(idx1), 32'(i % 16));
      chk($sformatf("fp%0d idx", i), 32'(idx0), 32'd0);
    end
    req = '0;

    // Asynchronous reset in the middle of a held transfer with merged high.
    do_reset();
    req = 16'h0004; out_ready = 1'b0;
    step();
    req = '0;
    step();
    chk("hold valid", 32'(v0), 32'd1);
    chk("hold idx", 32'(idx0), 32'd2);
    req = 16'h0004;
    step();
    step();
    chk("hold merged", 32'(m0), 32'd1);
    chk("hold pending", 32'(pend0), 32'h0004);
    #2 rst_n = 1'b0;
    #1;
    chk_reset0("midreset");
    req = '0;
    step();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encod16x4_queue.md
# encod16x4_queue

Sequential 16-to-4 event encoder: collects one-hot or multi-hot event lines into a 16-bit pending set and emits each pending line as a 4-bit binary index over a valid/ready handshake. It is the inverse companion of the 4-to-16 one-hot decoder. Index `n` corresponds to bit `n` (bit 0 ↔ 4'b0000). It sits between the peripheral event lines and the control unit that consumes binary indices.

## Interface
- `RR`, default 0: 0 = fixed priority, lowest index first; 1 = round-robin, starting after the last emitted index.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 16: event lines, sampled every cycle. A 1 sets the matching pending bit.
- `flush` in 1: synchronous clear of the pending set and the output stage.
- `out_ready` in 1: consumer accepts the index.
- `out_valid` out 1: `out_idx` is valid.
- `out_idx` out 4: binary index of the presented event.
- `pending` out 16: registered pending set. It excludes the index currently presented.
- `busy` out 1: `out_valid | (|pending)`, combinational from registers.
- `merged` out 1: registered pulse, one cycle. Set when any `req` bit hit an already-pending bit.

## Operation
- Pending update each cycle: `pending_next = (pending & ~load_mask) | req`.
  - `load_mask` is the one-hot of the index loaded into the output stage this cycle, or 0 if none.
  - `req` wins over clearing for the same bit, so a re-assertion during load re-queues the index.
- Duplicate requests for a bit already pending are coalesced into one emission. `merged` flags this the next cycle.
- A `req` for the index currently presented is not a duplicate. It sets the pending bit and causes a second emission.
- State machine, two states:
  - IDLE: `out_valid`=0. If `pending != 0`, load the selected index and go to HOLD.
  - HOLD: `out_valid`=1, `out_idx` is held stable.
    - If `out_ready`=0: stay.
    - If `out_ready`=1 and `pending != 0`: load the next index the same edge and stay in HOLD (back-to-back).
    - If `out_ready`=1 and `pending == 0`: go to IDLE.
- Selection:
  - RR=0: lowest set bit of `pending`.
  - RR=1: first set bit searching from `(last_idx+1) mod 16` upward, wrapping 15→0.
  - `last_idx` resets to 4'd15, so the first RR search starts at 0.
  - `last_idx` updates on every load.
- Selection uses only registered `pending`, never the live `req`.
- `flush` has priority over everything except reset:
  - Next edge: `pending`=0, `out_valid`=0, state IDLE, `merged`=0.
  - `req` in the flush cycle is discarded.
  - `last_idx` is kept.
- Reset values: `pending`=16'h0000, `out_valid`=0, `out_idx`=4'h0, `merged`=0, `last_idx`=4'hF, state IDLE, hence `busy`=0.
- Reset asserted mid-handshake drops everything immediately. No emission completes.

## Timing
- Latency:
  - `req` bit high at edge k → `pending` bit set after edge k.
  - `out_valid`/`out_idx` appear after edge k+1, if the output stage was IDLE.
- Throughput: one index per cycle while `out_ready`=1 and `pending` is non-empty.
- Handshake: a transfer occurs on an edge with `out_valid & out_ready`. `out_idx` must not change while `out_valid`=1 and `out_ready`=0.
- `out_ready` while `out_valid`=0 is ignored.
- All 16 bits pending with `out_ready` held at 1: indices stream out on 16 consecutive cycles, then `out_valid` drops.
- `merged` is high in the cycle after the colliding `req`.

## Structure
- Shared package `encod_pkg`: `IDX_W`=4, `N_LINES`=16, state enum `{ENC_IDLE, ENC_HOLD}`.
- One sub-module, `prio_sel16`: combinational first-set-bit finder over 16 bits with a 4-bit start offset. It returns `found` and `idx`. RR=0 ties the offset to 0.
- The top level holds the pending register, output register, `last_idx`, FSM and `merged` logic.

## Test plan
- Reset, then single `req`=16'h0020 for one cycle with `out_ready`=1 → `out_valid` for exactly one cycle, 2 edges after the req edge, with `out_idx`=4'd5; then `busy`=0.
- RR=0, `req`=16'h8421 for one cycle, `out_ready`=1 → `out_idx` sequence 0, 5, 10, 15 on consecutive cycles.
- RR=1, `req`=16'hFFFF held, `out_ready`=1 → indices 0..15 in order, then wrap back to 0. No index repeats within any 16 consecutive transfers.
- Backpressure: `req`=16'h0003, `out_ready`=0 for 5 cycles → `out_idx`=0 held stable and `pending`=16'h0002; release `out_ready` → 0 then 1 transferred.
- Coalescing: `req`=16'h0010 on two consecutive cycles while 4 is still pending → `merged` pulses once and index 4 is emitted once. Re-asserting `req`=16'h0010 while 4 is presented causes a second emission of 4.
- `flush` with `pending`=16'h00F0 and `out_valid`=1, `req`=16'h0001 in the same cycle → next cycle `pending`=0, `out_valid`=0, `busy`=0. Reset mid-HOLD → all outputs at reset values immediately.
